// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl
//   Drives a 16-bit LED bank from a 16-bit switch bank.
//   Four debounced push-buttons select how the switches map onto the LEDs.
//
// Ports
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset
//   sw[15:0]                switch bank, asynchronous to clk
//   btnu, btnd, btnl, btnr  raw push-buttons, asynchronous and bouncing
//   led[15:0]               registered LED pattern
//   mode[2:0]               registered current mode
//
// Mode FSM
//   state    | meaning
//   PASS  0  | led follows the synchronized switches
//   XOR   1  | led[7:0] = upper switch byte XOR lower switch byte
//   ALL1  2  | led[0] set only when every switch is on
//   SHIFT 3  | switches shifted left by 3, zero-filled
//   CLEAR 4  | all LEDs off; returns to PASS after CLEAR_TICKS cycles
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CLEAR_TICKS     = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  output logic [15:0] led,
  output logic [2:0]  mode
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_TICKS - 1);

  typedef enum logic [2:0] {
    ST_PASS  = 3'd0,
    ST_XOR   = 3'd1,
    ST_ALL1  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CLEAR = 3'd4
  } mode_t;

  // Button vectors are indexed {btnl, btnr, btnd, btnu} = [3:0]
  logic [15:0]   sw_meta, ssw;
  logic [3:0]    btn_meta, bsync;
  logic [3:0]    acc;
  logic [3:0]    pulse;
  logic [DW-1:0] db_cnt [4];
  logic [TW-1:0] clr_cnt;
  mode_t         state;

  logic          has_pulse;
  mode_t         target;

  // Two-flop synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      ssw      <= '0;
      btn_meta <= '0;
      bsync    <= '0;
    end else begin
      sw_meta  <= sw;
      ssw      <= sw_meta;
      btn_meta <= {btnl, btnr, btnd, btnu};
      bsync    <= btn_meta;
    end
  end

  // Debounce: a level is accepted once it has differed from the accepted
  // level for DEBOUNCE_CYCLES consecutive cycles. The press pulse is
  // registered alongside the accepted level, so it is high for the single
  // cycle following the accepted rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      pulse <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pulse[i] <= 1'b0;
        if (bsync[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          acc[i]    <= bsync[i];
          db_cnt[i] <= '0;
          pulse[i]  <= bsync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Priority select among simultaneous pulses: btnl > btnr > btnd > btnu
  always_comb begin
    has_pulse = 1'b1;
    target    = ST_PASS;
    if (pulse[3])      target = ST_XOR;
    else if (pulse[2]) target = ST_ALL1;
    else if (pulse[1]) target = ST_SHIFT;
    else if (pulse[0]) target = ST_CLEAR;
    else               has_pulse = 1'b0;
  end

  // Mode FSM; pressing the button of the current mode toggles back to PASS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_PASS;
      clr_cnt <= '0;
    end else begin
      clr_cnt <= '0;
      case (state)
        ST_PASS, ST_XOR, ST_ALL1, ST_SHIFT, ST_CLEAR: begin
          if (has_pulse) begin
            state <= (target == state) ? ST_PASS : target;
          end else if (state == ST_CLEAR) begin
            if (clr_cnt == CLR_LAST) state <= ST_PASS;
            else                     clr_cnt <= clr_cnt + TW'(1);
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

  assign mode = state;

  // Output register, driven from the registered mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      case (state)
        ST_PASS:  led <= ssw;
        ST_XOR:   led <= {8'h00, ssw[15:8] ^ ssw[7:0]};
        ST_ALL1:  led <= {15'd0, &ssw};
        ST_SHIFT: led <= {ssw[12:0], 3'b000};
        default:  led <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
  logic [15:0] led;
  logic [2:0]  mode;

  int vec_cnt = 0;
  int err_cnt = 0;

  led_mode_ctrl #(.DEBOUNCE_CYCLES(4), .CLEAR_TICKS(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
    .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1ns later
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Release all buttons and let the release debounce settle (no pulse)
  task automatic release_all();
    btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnr = 1'b0;
    tick(8);
  endtask

  // A clean press asserted here reaches mode 7 edges later:
  // 2 sync + 4 debounce (pulse registered) + 1 FSM
  initial begin
    int changes;
    logic [2:0] prev;

    // Reset
    #2;
    check("rst_mode", {13'd0, mode}, 16'h0000);
    check("rst_led", led, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // PASS with switch latency of 3 cycles
    sw = 16'h1234;
    tick(2);
    check("pass_lat2", led, 16'h0000);
    tick(1);
    check("pass_lat3", led, 16'h1234);
    check("pass_mode", {13'd0, mode}, 16'h0000);

    // XOR and toggle back
    sw = 16'hA55A;
    tick(3);
    btnl = 1'b1;
    tick(6);
    check("xor_mode_early", {13'd0, mode}, 16'h0000);
    tick(1);
    check("xor_mode", {13'd0, mode}, 16'h0001);
    check("xor_led_prev", led, 16'hA55A);
    tick(1);
    check("xor_led", led, 16'h00FF);
    release_all();
    btnl = 1'b1;
    tick(7);
    check("xor_toggle_mode", {13'd0, mode}, 16'h0000);
    tick(1);
    check("xor_toggle_led", led, 16'hA55A);
    release_all();

    // ALL1
    sw = 16'hFFFF;
    tick(3);
    btnr = 1'b1;
    tick(7);
    check("all1_mode", {13'd0, mode}, 16'h0002);
    tick(1);
    check("all1_led", led, 16'h0001);
    sw = 16'hFFFE;
    tick(2);
    check("all1_lat2", led, 16'h0001);
    tick(1);
    check("all1_lat3", led, 16'h0000);
    release_all();

    // SHIFT
    sw = 16'hF001;
    tick(3);
    btnd = 1'b1;
    tick(7);
    check("shift_mode", {13'd0, mode}, 16'h0003);
    tick(1);
    check("shift_led", led, 16'h8008);
    release_all();

    // Bounce on btnr: 2-cycle glitches never reach acceptance
    changes = 0;
    prev = mode;
    for (int i = 0; i < 10; i++) begin
      btnr = ~btnr;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (mode !== prev) changes++;
        prev = mode;
      end
    end
    btnr = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      if (mode !== prev) changes++;
      prev = mode;
    end
    check("bounce_no_early", {13'd0, mode}, 16'h0003);
    tick(1);
    if (mode !== prev) changes++;
    check("bounce_mode", {13'd0, mode}, 16'h0002);
    check("bounce_one_change", 16'(changes), 16'd1);
    release_all();

    // Simultaneous btnl + btnu: btnl wins
    btnl = 1'b1;
    btnu = 1'b1;
    tick(7);
    check("simul_mode", {13'd0, mode}, 16'h0001);
    tick(1);
    check("simul_led", led, 16'h00F1);
    release_all();

    // CLEAR with timeout after 16 cycles
    btnu = 1'b1;
    tick(7);
    check("clear_mode", {13'd0, mode}, 16'h0004);
    btnu = 1'b0;
    tick(1);
    check("clear_led", led, 16'h0000);
    tick(14);
    check("clear_hold15", {13'd0, mode}, 16'h0004);
    tick(1);
    check("clear_timeout", {13'd0, mode}, 16'h0000);
    tick(1);
    check("clear_timeout_led", led, 16'hF001);
    tick(4);

    // CLEAR overridden by btnd whose pulse lands at tick 8
    btnu = 1'b1;
    tick(7);
    check("clear2_mode", {13'd0, mode}, 16'h0004);
    btnu = 1'b0;
    tick(2);
    btnd = 1'b1;
    tick(6);
    check("override_before", {13'd0, mode}, 16'h0004);
    tick(1);
    check("override_mode", {13'd0, mode}, 16'h0003);
    tick(1);
    check("override_led", led, 16'h8008);
    release_all();

    // Reset asserted mid-CLEAR
    btnu = 1'b1;
    tick(7);
    check("clear3_mode", {13'd0, mode}, 16'h0004);
    btnu = 1'b0;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mode", {13'd0, mode}, 16'h0000);
    check("async_rst_led", led, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    changes = 0;
    prev = mode;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      if (mode !== prev) changes++;
      prev = mode;
    end
    check("post_rst_mode", {13'd0, mode}, 16'h0000);
    check("post_rst_stable", 16'(changes), 16'd0);
    check("post_rst_led", led, 16'hF001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
